// File: rtl/lfsr_stream.sv
// Word-wide PRBS source: an nbits LFSR (Fibonacci or Galois, chosen at load time)
// advanced obits steps per word, delivered through a one-entry valid/ready buffer.
module lfsr_stream #(
    parameter int nbits = 8,
    parameter int obits = 4,
    parameter int cbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [nbits-1:0] seed,
    input  logic [nbits-1:0] tap,
    input  logic             mode,
    input  logic             enable,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [obits-1:0] out_data,
    output logic             stuck,
    output logic [cbits-1:0] count
);

    // Handshake: a word transfers on a rising edge where out_val and out_rdy are both
    // high; out_val and out_data stay put until that transfer, a load or a reset.
    localparam logic [0:0] BUF_EMPTY = 1'b0;
    localparam logic [0:0] BUF_FULL  = 1'b1;

    localparam logic [nbits-1:0] STATE_ONE = {{(nbits-1){1'b0}}, 1'b1};

    logic [0:0]       buf_q, buf_d;
    logic [nbits-1:0] state_q, state_d;
    logic [nbits-1:0] tap_q, tap_d;
    logic             mode_q, mode_d;
    logic [obits-1:0] data_q, data_d;
    logic             stuck_q, stuck_d;
    logic [cbits-1:0] count_q, count_d;

    logic [nbits-1:0] adv_state;
    logic [obits-1:0] word;
    logic             gen;
    logic             fire;

    assign out_val  = (buf_q == BUF_FULL);
    assign out_data = data_q;
    assign stuck    = stuck_q;
    assign count    = count_q;

    assign gen  = enable & ~load & ~stuck_q & (~out_val | out_rdy);
    assign fire = out_val & out_rdy;

    // Unrolled obits single steps; the earliest bit ends up in the word MSB.
    always_comb begin
        logic [nbits-1:0] walk;
        logic             step_bit;
        walk     = state_q;
        word     = '0;
        step_bit = 1'b0;
        for (int k = 0; k < obits; k++) begin
            step_bit = walk[nbits-1];
            word     = (word << 1) | obits'(step_bit);
            if (mode_q) begin
                walk = {walk[nbits-2:0], 1'b0} ^ (step_bit ? tap_q : '0);
            end else begin
                walk = {walk[nbits-2:0], ^(walk & tap_q)};
            end
        end
        adv_state = walk;
    end

    always_comb begin
        buf_d   = buf_q;
        state_d = state_q;
        tap_d   = tap_q;
        mode_d  = mode_q;
        data_d  = data_q;
        stuck_d = stuck_q;
        count_d = count_q;
        if (load) begin
            // An all-zero seed would lock the register; restart from 1 instead.
            state_d = (seed == '0) ? STATE_ONE : seed;
            tap_d   = tap;
            mode_d  = mode;
            buf_d   = BUF_EMPTY;
            data_d  = '0;
            stuck_d = 1'b0;
            count_d = '0;
        end else begin
            if (gen) begin
                state_d = adv_state;
                data_d  = word;
                count_d = count_q + cbits'(1);
                stuck_d = (adv_state == '0);
            end
            case (buf_q)
                BUF_EMPTY: if (gen) buf_d = BUF_FULL;
                BUF_FULL:  if (fire && !gen) buf_d = BUF_EMPTY;
                default:   buf_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q   <= BUF_EMPTY;
            state_q <= STATE_ONE;
            tap_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            stuck_q <= 1'b0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            state_q <= state_d;
            tap_q   <= tap_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            stuck_q <= stuck_d;
            count_q <= count_d;
        end
    end

    // A held word must neither vanish nor change while the consumer stalls.
    a_hold_under_backpressure: assert property (
        @(posedge clk) disable iff (reset)
        (out_val && !out_rdy && !load) |=> (out_val && $stable(out_data))
    );

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: a 4/4/16 instance for word streams and a 4/1/4 instance
// for the single-bit period and counter wrap; expected words come from a spec model.
module tb_lfsr_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, load, mode, enable, out_rdy;
    logic [3:0] seed, tap;

    logic        w_val, w_stuck;
    logic [3:0]  w_data;
    logic [15:0] w_count;
    logic        b_val, b_stuck;
    logic [0:0]  b_data;
    logic [3:0]  b_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic [0:0] bit_q[$];

    logic [3:0] m_state, m_tap;
    logic       m_mode;

    lfsr_stream #(.nbits(4), .obits(4), .cbits(16)) dut_w (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .tap(tap), .mode(mode),
        .enable(enable), .out_val(w_val), .out_rdy(out_rdy), .out_data(w_data),
        .stuck(w_stuck), .count(w_count)
    );

    lfsr_stream #(.nbits(4), .obits(1), .cbits(4)) dut_b (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .tap(tap), .mode(mode),
        .enable(enable), .out_val(b_val), .out_rdy(out_rdy), .out_data(b_data),
        .stuck(b_stuck), .count(b_count)
    );

    // Reference: ob single steps from the model state, earliest bit in the MSB.
    task automatic model_word(input int ob, output logic [3:0] w);
        logic b;
        w = '0;
        for (int k = 0; k < ob; k++) begin
            b = m_state[3];
            w = {w[2:0], b};
            if (m_mode) m_state = {m_state[2:0], 1'b0} ^ (b ? m_tap : 4'b0000);
            else        m_state = {m_state[2:0], ^(m_state & m_tap)};
        end
    endtask

    task automatic do_load(input logic [3:0] s, input logic [3:0] t, input logic md);
        @(posedge clk); #1;
        load = 1'b1; seed = s; tap = t; mode = md;
        @(posedge clk); #1;
        load = 1'b0;
        m_state = (s == 4'b0000) ? 4'b0001 : s;
        m_tap   = t;
        m_mode  = md;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (w_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b exp 0", w_val); end
        checks++; if (w_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h exp 0", w_data); end
        checks++; if (w_stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got %b exp 0", w_stuck); end
        checks++; if (w_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", w_count); end
        checks++; if (dut_w.state_q !== 4'b0001) begin errors++; $display("FAIL reset_state got %b exp 0001", dut_w.state_q); end
        checks++; if (dut_w.tap_q !== 4'b0000) begin errors++; $display("FAIL reset_tap got %b exp 0000", dut_w.tap_q); end
        reset = 1'b0;
    endtask

    task automatic test_fib_stream();
        logic [3:0] w, e;
        enable = 1'b0; out_rdy = 1'b1;
        do_load(4'b0001, 4'b1100, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin model_word(4, w); exp_q.push_back(w); end
        @(negedge clk);
        checks++; if (w_val !== 1'b0) begin errors++; $display("FAIL fib_load_latency out_val got %b exp 0", w_val); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (w_val !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL fib_valid word %0d out_val got %b exp 1", n, w_val);
            end else begin
                e = exp_q.pop_front();
                if (w_data !== e) begin errors++; $display("FAIL fib_word%0d got %b exp %b", n, w_data, e); end
            end
            if (n == 0) begin
                checks++; if (w_data !== 4'b0001) begin errors++; $display("FAIL fib_first got %b exp 0001", w_data); end
            end
            if (n == 1) begin
                checks++; if (w_data !== 4'b0011) begin errors++; $display("FAIL fib_second got %b exp 0011", w_data); end
                checks++; if (w_count !== 16'd2) begin errors++; $display("FAIL fib_count got %0d exp 2", w_count); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_galois_stream();
        logic [3:0] w, e;
        enable = 1'b0; out_rdy = 1'b1;
        do_load(4'b0001, 4'b0011, 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin model_word(4, w); exp_q.push_back(w); end
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if (w_val !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL gal_valid word %0d out_val got %b exp 1", n, w_val);
            end else begin
                e = exp_q.pop_front();
                if (w_data !== e) begin errors++; $display("FAIL gal_word%0d got %b exp %b", n, w_data, e); end
            end
            if (n == 0) begin
                checks++; if (w_data !== 4'b0001) begin errors++; $display("FAIL gal_first got %b exp 0001", w_data); end
                checks++; if (dut_w.state_q !== 4'b0011) begin errors++; $display("FAIL gal_state got %b exp 0011", dut_w.state_q); end
            end
            if (n == 1) begin
                checks++; if (w_data !== 4'b0011) begin errors++; $display("FAIL gal_second got %b exp 0011", w_data); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_period_wrap();
        logic [3:0] w, e;
        logic [0:0] first;
        enable = 1'b0; out_rdy = 1'b1;
        do_load(4'b0001, 4'b1100, 1'b0);
        enable = 1'b1;
        bit_q.delete();
        for (int i = 0; i < 30; i++) begin model_word(1, w); exp_q.push_back(w); end
        @(negedge clk);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            checks++;
            if (b_val !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL per_valid bit %0d out_val got %b exp 1", n, b_val);
            end else begin
                e = exp_q.pop_front();
                if (b_data !== e[0:0]) begin errors++; $display("FAIL per_bit%0d got %b exp %b", n, b_data, e[0]); end
            end
            if (n < 15) begin
                bit_q.push_back(b_data);
            end else begin
                first = bit_q.pop_front();
                checks++;
                if (b_data !== first) begin errors++; $display("FAIL per_repeat bit %0d got %b exp %b", n, b_data, first); end
            end
            if (n == 14) begin
                checks++; if (b_count !== 4'd15) begin errors++; $display("FAIL per_count15 got %0d exp 15", b_count); end
            end
            if (n == 15) begin
                checks++; if (b_count !== 4'd0) begin errors++; $display("FAIL per_wrap got %0d exp 0", b_count); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_lockup();
        enable = 1'b0; out_rdy = 1'b0;
        do_load(4'b0001, 4'b0000, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (w_val !== 1'b1) begin errors++; $display("FAIL lock_val got %b exp 1", w_val); end
        checks++; if (w_data !== 4'b0001) begin errors++; $display("FAIL lock_word got %b exp 0001", w_data); end
        checks++; if (w_stuck !== 1'b1) begin errors++; $display("FAIL lock_stuck got %b exp 1", w_stuck); end
        out_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (w_val !== 1'b0) begin errors++; $display("FAIL lock_no_gen cycle %0d out_val got %b exp 0", n, w_val); end
            checks++; if (w_count !== 16'd1) begin errors++; $display("FAIL lock_count cycle %0d got %0d exp 1", n, w_count); end
        end
        do_load(4'b0000, 4'b1100, 1'b0);
        @(negedge clk);
        checks++; if (w_stuck !== 1'b0) begin errors++; $display("FAIL lock_clear got %b exp 0", w_stuck); end
        checks++; if (dut_w.state_q !== 4'b0001) begin errors++; $display("FAIL lock_zero_seed state got %b exp 0001", dut_w.state_q); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] w, e, held;
        enable = 1'b0; out_rdy = 1'b0;
        do_load(4'b0001, 4'b1100, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin model_word(4, w); exp_q.push_back(w); end
        @(negedge clk);
        @(negedge clk);
        held = w_data;
        checks++; if (w_val !== 1'b1 || w_data !== exp_q[0]) begin errors++; $display("FAIL bp_first val %b got %b exp %b", w_val, w_data, exp_q[0]); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++; if (w_val !== 1'b1 || w_data !== held) begin errors++; $display("FAIL bp_hold cycle %0d got %b exp %b", n, w_data, held); end
            checks++; if (w_count !== 16'd1) begin errors++; $display("FAIL bp_count cycle %0d got %0d exp 1", n, w_count); end
        end
        out_rdy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (w_val !== 1'b1 || w_data !== e) begin errors++; $display("FAIL bp_release word %0d got %b exp %b", n, w_data, e); end
            checks++; if (w_count !== 16'(n + 1)) begin errors++; $display("FAIL bp_release_count word %0d got %0d exp %0d", n, w_count, n + 1); end
        end
        enable = 1'b0;
    endtask

    task automatic test_priority();
        logic [3:0] w, e;
        enable = 1'b0; out_rdy = 1'b1;
        do_load(4'b0001, 4'b1100, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; seed = 4'b0101; tap = 4'b1100; mode = 1'b0;
        @(negedge clk);
        checks++; if (w_val !== 1'b0) begin errors++; $display("FAIL prio_val got %b exp 0", w_val); end
        checks++; if (w_count !== 16'd0) begin errors++; $display("FAIL prio_count got %0d exp 0", w_count); end
        checks++; if (dut_w.state_q !== 4'b0101) begin errors++; $display("FAIL prio_state got %b exp 0101", dut_w.state_q); end
        load = 1'b0;
        m_state = 4'b0101; m_tap = 4'b1100; m_mode = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin model_word(4, w); exp_q.push_back(w); end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (w_val !== 1'b1 || w_data !== e) begin errors++; $display("FAIL prio_restart word %0d got %b exp %b", n, w_data, e); end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (w_val !== 1'b0 || w_data !== 4'h0) begin errors++; $display("FAIL midreset_out val %b data %b exp 0 0000", w_val, w_data); end
        checks++; if (w_count !== 16'd0 || w_stuck !== 1'b0) begin errors++; $display("FAIL midreset_cnt count %0d stuck %b exp 0 0", w_count, w_stuck); end
        checks++; if (dut_w.state_q !== 4'b0001) begin errors++; $display("FAIL midreset_state got %b exp 0001", dut_w.state_q); end
        reset = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_random_rdy();
        logic [3:0] w, e, s;
        logic       md;
        int         popped;
        for (int r = 0; r < 3; r++) begin
            s  = 4'($urandom_range(1, 15));
            md = 1'($urandom_range(0, 1));
            enable = 1'b0; out_rdy = 1'b0;
            do_load(s, md ? 4'b0011 : 4'b1100, md);
            enable = 1'b1;
            for (int i = 0; i < 20; i++) begin model_word(4, w); exp_q.push_back(w); end
            popped = 0;
            for (int cyc = 0; cyc < 400 && popped < 20; cyc++) begin
                @(posedge clk); #1;
                out_rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (w_val && out_rdy) begin
                    e = exp_q.pop_front();
                    popped++;
                    checks++;
                    if (w_data !== e) begin errors++; $display("FAIL rand_word run %0d word %0d got %b exp %b", r, popped, w_data, e); end
                end
            end
            checks++;
            if (popped != 20) begin errors++; $display("FAIL rand_timeout run %0d words %0d exp 20", r, popped); end
        end
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; seed = '0; tap = '0; mode = 1'b0;
        enable = 1'b0; out_rdy = 1'b0;
        m_state = 4'b0001; m_tap = '0; m_mode = 1'b0;
        test_reset();
        test_fib_stream();
        test_galois_stream();
        test_period_wrap();
        test_lockup();
        test_backpressure();
        test_priority();
        test_random_rdy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
